add_sched: RTL

ADD_SCHED -- requirements
Module: add_sched

---
 rtl/add_sched_pkg.sv | 14 +
 rtl/add_sched_rr_arbiter.sv | 36 +++
 rtl/add_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/add_sched_pkg.sv
// Shared types and defaults for the shared-adder scheduler.
// Imported by the arbiter and the top so state encoding stays in one place.
package add_sched_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_sched_rr_arbiter.sv
// Round-robin picker: scans from ptr upward, wrapping at N-1, first requester wins.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
    import add_sched_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = $clog2(N_REQ_DEF)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any       = 1'b1;
                winner[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/add_sched.sv
// Time-shares one adder between N_REQ requesters: grant/capture, add, then hold
// the result until the consumer accepts it.
module add_sched
    import add_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] opa,
    input  logic [N_REQ*W-1:0] opb,
    output logic [N_REQ-1:0]   gnt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IW-1:0]      rsp_id,
    output logic [W:0]         rsp_sum,
    output logic               busy
);

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [IW-1:0]    id_q, id_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]    rsp_id_q, rsp_id_d;
    logic [W:0]       rsp_sum_q, rsp_sum_d;

    logic [N_REQ-1:0] arb_win;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic [W:0]       sum;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_win),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    // The only adder; it always works on the captured operands.
    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        gnt_d       = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    a_d     = opa[arb_idx*W +: W];
                    b_d     = opb[arb_idx*W +: W];
                    id_d    = arb_idx;
                    gnt_d   = arb_win;
                    ptr_d   = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rsp_sum_d   = sum;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
